// File: rtl/rob_param_if.sv
// Reorder buffer bus bundle: allocate, CDB write-back, commit and status.
//   alloc_*   : rename-side allocation request/grant (alloc_tag = granted tag)
//   cdb_*     : NUM_CDB packed result ports; port k at [k*W +: W]
//   commit_*  : head-of-buffer retire handshake (valid/ack)
//   flush     : discard every entry
//   count     : number of valid entries, empty = (count == 0)
// The slave modport is the ROB itself; the master modport is the core around it.
interface rob_param_if #(
    parameter int DEPTH   = 16,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 32,
    parameter int AREG_W  = 5,
    parameter int NUM_CDB = 2
);
    logic                      alloc_valid;
    logic [AREG_W-1:0]         alloc_areg;
    logic                      alloc_store;
    logic                      alloc_ready;
    logic [TAG_W-1:0]          alloc_tag;
    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
    logic [NUM_CDB*DATA_W-1:0] cdb_val;
    logic [NUM_CDB-1:0]        cdb_exc;
    logic                      commit_valid;
    logic [TAG_W-1:0]          commit_tag;
    logic [AREG_W-1:0]         commit_areg;
    logic [DATA_W-1:0]         commit_val;
    logic                      commit_store;
    logic                      commit_exc;
    logic                      commit_ack;
    logic                      flush;
    logic [TAG_W:0]            count;
    logic                      empty;

    modport slave (
        input  alloc_valid, alloc_areg, alloc_store,
        output alloc_ready, alloc_tag,
        input  cdb_valid, cdb_tag, cdb_val, cdb_exc,
        output commit_valid, commit_tag, commit_areg, commit_val, commit_store, commit_exc,
        input  commit_ack, flush,
        output count, empty
    );

    modport master (
        output alloc_valid, alloc_areg, alloc_store,
        input  alloc_ready, alloc_tag,
        output cdb_valid, cdb_tag, cdb_val, cdb_exc,
        input  commit_valid, commit_tag, commit_areg, commit_val, commit_store, commit_exc,
        output commit_ack, flush,
        input  count, empty
    );
endinterface

// File: rtl/rob_param.sv
// Parametrised reorder buffer. Circular queue of in-flight instructions:
// entries are allocated at tail in program order, completed out of order by
// NUM_CDB result buses, and retired in order from head via commit valid/ack.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-high reset
//   bus  : rob_param_if.slave (alloc, CDB, commit, flush, count/empty)
// All outputs are combinational from registered state. TAG_W must equal
// log2(DEPTH) so that tags wrap naturally with the head/tail pointers.
module rob_param #(
    parameter int DEPTH   = 16,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 32,
    parameter int AREG_W  = 5,
    parameter int NUM_CDB = 2
) (
    input  logic         clk,
    input  logic         rst,
    rob_param_if.slave   bus
);
    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0]              valid, ready, exc, store;
    logic [DEPTH-1:0][AREG_W-1:0]  areg;
    logic [DEPTH-1:0][DATA_W-1:0]  val;
    logic [TAG_W-1:0]              head, tail;
    logic [TAG_W:0]                cnt;

    logic                          alloc_ready, commit_valid;
    logic                          do_alloc, do_commit;

    // Per-entry CDB hit, already resolved across ports.
    logic [DEPTH-1:0]              hit, hit_exc;
    logic [DEPTH-1:0][DATA_W-1:0]  hit_val;

    assign alloc_ready  = (cnt != FULL_CNT);
    assign commit_valid = valid[head] & ready[head];
    // Flush masks every other action in its cycle.
    assign do_alloc     = bus.alloc_valid & alloc_ready & ~bus.flush;
    assign do_commit    = commit_valid & bus.commit_ack & ~bus.flush;

    assign bus.alloc_ready  = alloc_ready;
    assign bus.alloc_tag    = tail;
    assign bus.commit_valid = commit_valid;
    assign bus.commit_tag   = head;
    assign bus.commit_areg  = areg[head];
    assign bus.commit_val   = val[head];
    assign bus.commit_store = store[head];
    assign bus.commit_exc   = exc[head];
    assign bus.count        = cnt;
    assign bus.empty        = (cnt == '0);

    // Ports scanned high to low so the lowest matching port is the last
    // assignment and therefore wins on a tag collision.
    always_comb begin
        hit     = '0;
        hit_exc = '0;
        hit_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = NUM_CDB-1; k >= 0; k--) begin
                if (bus.cdb_valid[k] && bus.cdb_tag[k*TAG_W +: TAG_W] == TAG_W'(i)) begin
                    hit[i]     = 1'b1;
                    hit_exc[i] = bus.cdb_exc[k];
                    hit_val[i] = bus.cdb_val[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (bus.flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (do_alloc)  tail <= tail + 1'b1;
            if (do_commit) head <= head + 1'b1;
            case ({do_alloc, do_commit})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Commit beats a same-cycle CDB write to the head. Alloc and commit never
    // target the same slot (that needs count==0 or count==DEPTH), and a CDB
    // write to the freshly allocated slot is dropped since it is still invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            ready <= '0;
            exc   <= '0;
            store <= '0;
            areg  <= '0;
            val   <= '0;
        end else if (bus.flush) begin
            valid <= '0;
            ready <= '0;
            exc   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (do_commit && head == TAG_W'(i)) begin
                    valid[i] <= 1'b0;
                    ready[i] <= 1'b0;
                end else if (do_alloc && tail == TAG_W'(i)) begin
                    valid[i] <= 1'b1;
                    ready[i] <= 1'b0;
                    exc[i]   <= 1'b0;
                    store[i] <= bus.alloc_store;
                    areg[i]  <= bus.alloc_areg;
                end else if (hit[i] && valid[i]) begin
                    ready[i] <= 1'b1;
                    exc[i]   <= hit_exc[i];
                    val[i]   <= hit_val[i];
                end
            end
        end
    end
endmodule
